// File: rtl/line_draw_sched_if.sv
// line_draw_sched_if: bundles the requester, engine and status signals of the
// frame scheduler.
//   master : environment side (tick source, requesters, draw engine)
//   slave  : the scheduler itself
// Signals:
//   frame_tick, req_valid, req_x0/y0/x1/y1, eng_waiting   -> scheduler
//   req_ack, eng_clear, eng_start, eng_x0/y0/x1/y1,
//   busy, frame_done, overrun_cnt                         <- scheduler
interface line_draw_sched_if #(
    parameter int unsigned P_N_REQ   = 4,
    parameter int unsigned P_COORD_W = 16
) ();
    logic                             frame_tick;
    logic [P_N_REQ-1:0]               req_valid;
    logic [P_N_REQ*P_COORD_W-1:0]     req_x0;
    logic [P_N_REQ*P_COORD_W-1:0]     req_y0;
    logic [P_N_REQ*P_COORD_W-1:0]     req_x1;
    logic [P_N_REQ*P_COORD_W-1:0]     req_y1;
    logic [P_N_REQ-1:0]               req_ack;
    logic                             eng_waiting;
    logic                             eng_clear;
    logic                             eng_start;
    logic signed [P_COORD_W-1:0]      eng_x0;
    logic signed [P_COORD_W-1:0]      eng_y0;
    logic signed [P_COORD_W-1:0]      eng_x1;
    logic signed [P_COORD_W-1:0]      eng_y1;
    logic                             busy;
    logic                             frame_done;
    logic [7:0]                       overrun_cnt;

    modport master (
        output frame_tick, req_valid, req_x0, req_y0, req_x1, req_y1, eng_waiting,
        input  req_ack, eng_clear, eng_start, eng_x0, eng_y0, eng_x1, eng_y1,
               busy, frame_done, overrun_cnt
    );

    modport slave (
        input  frame_tick, req_valid, req_x0, req_y0, req_x1, req_y1, eng_waiting,
        output req_ack, eng_clear, eng_start, eng_x0, eng_y0, eng_x1, eng_y1,
               busy, frame_done, overrun_cnt
    );
endinterface

// File: rtl/line_draw_sched.sv
// line_draw_sched: shares one draw_lines engine between P_N_REQ requesters.
// Each frame tick clears the buffer, then grants requesters round-robin (each
// at most once per frame), latching their endpoints and starting one draw.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : line_draw_sched_if.slave (requesters, engine handshake, status)
// Build option: define LINE_SCHED_CLIP_EN to clamp latched endpoints to the
// screen area [0, P_SCREEN_W-1] x [0, P_SCREEN_H-1].
module line_draw_sched #(
    parameter int unsigned P_N_REQ    = 4,
    parameter int unsigned P_COORD_W  = 16,
    parameter int unsigned P_SCREEN_W = 640,
    parameter int unsigned P_SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    line_draw_sched_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(P_N_REQ);
    localparam int unsigned CNT_W = 8;

`ifdef LINE_SCHED_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef logic signed [P_COORD_W-1:0] coord_t;

    localparam coord_t X_MAX = coord_t'(P_SCREEN_W - 1);
    localparam coord_t Y_MAX = coord_t'(P_SCREEN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_CLR_WAIT, S_ARB, S_ISSUE, S_DRAW_WAIT, S_DONE
    } state_e;

    // Signed clamp to [0, hi]; pass-through when clipping is not built in.
    function automatic coord_t clip(input coord_t v, input coord_t hi);
        if (!CLIP_EN) return v;
        if (v < 0)    return '0;
        if (v > hi)   return hi;
        return v;
    endfunction

    state_e               state_q, state_d;
    logic                 first_q, first_d;
    logic [P_N_REQ-1:0]   served_q, served_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [P_N_REQ-1:0]   ack_q, ack_d;
    logic                 clear_q, clear_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     ovr_q, ovr_d;
    coord_t               x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;

    logic [P_N_REQ-1:0]   cand;
    logic                 found;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     search_idx;
    coord_t               sel_x0, sel_y0, sel_x1, sel_y1;

    // Next-state, arbitration and output decode
    always_comb begin
        state_d    = state_q;
        served_d   = served_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        clear_d    = 1'b0;
        start_d    = 1'b0;
        done_d     = 1'b0;
        ovr_d      = ovr_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        cand       = bus.req_valid & ~served_q;
        found      = 1'b0;
        pick       = '0;
        search_idx = '0;
        sel_x0     = '0;
        sel_y0     = '0;
        sel_x1     = '0;
        sel_y1     = '0;

        // First unserved valid requester at or above ptr, wrapping
        for (int k = 0; k < int'(P_N_REQ); k++) begin
            search_idx = IDX_W'((int'(ptr_q) + k) % int'(P_N_REQ));
            if (!found && cand[search_idx]) begin
                found = 1'b1;
                pick  = search_idx;
            end
        end

        // Endpoint mux for the current grant
        for (int i = 0; i < int'(P_N_REQ); i++) begin
            if (gnt_q == IDX_W'(i)) begin
                sel_x0 = bus.req_x0[i*P_COORD_W +: P_COORD_W];
                sel_y0 = bus.req_y0[i*P_COORD_W +: P_COORD_W];
                sel_x1 = bus.req_x1[i*P_COORD_W +: P_COORD_W];
                sel_y1 = bus.req_y1[i*P_COORD_W +: P_COORD_W];
            end
        end

        // Ticks outside IDLE are dropped and counted
        if (bus.frame_tick && (state_q != S_IDLE) && (ovr_q != {CNT_W{1'b1}})) begin
            ovr_d = ovr_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.frame_tick) begin
                    state_d  = S_CLR;
                    served_d = '0;
                end
            end
            S_CLR: begin
                if (bus.eng_waiting) begin
                    clear_d = 1'b1;
                    state_d = S_CLR_WAIT;
                end
            end
            // First cycle is a guard: the engine has not yet seen the pulse
            S_CLR_WAIT, S_DRAW_WAIT: begin
                if (!first_q && bus.eng_waiting) state_d = S_ARB;
            end
            S_ARB: begin
                if (found) begin
                    gnt_d   = pick;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_ISSUE: begin
                x0_d     = clip(sel_x0, X_MAX);
                y0_d     = clip(sel_y0, Y_MAX);
                x1_d     = clip(sel_x1, X_MAX);
                y1_d     = clip(sel_y1, Y_MAX);
                ack_d    = P_N_REQ'(1) << gnt_q;
                start_d  = 1'b1;
                served_d = served_q | (P_N_REQ'(1) << gnt_q);
                ptr_d    = (gnt_q == IDX_W'(P_N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
                state_d  = S_DRAW_WAIT;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        first_d = (state_d != state_q);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            first_q  <= 1'b0;
            served_q <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            clear_q  <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            served_q <= served_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            clear_q  <= clear_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
        end
    end

    assign bus.req_ack     = ack_q;
    assign bus.eng_clear   = clear_q;
    assign bus.eng_start   = start_q;
    assign bus.eng_x0      = x0_q;
    assign bus.eng_y0      = y0_q;
    assign bus.eng_x1      = x1_q;
    assign bus.eng_y1      = y1_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = done_q;
    assign bus.overrun_cnt = ovr_q;

endmodule

// File: doc/line_draw_sched.md
# line_draw_sched

Frame scheduler that shares the single `draw_lines` engine between up to `P_N_REQ` shape requesters (line, ball outline, cursor). On each frame tick it clears the frame buffer, then grants requesters round-robin, latches each one's endpoints, and starts one engine draw per grant. It sits between the motion/coordinate logic (`getCoords`-style tick sources) and `draw_lines`, and replaces the direct wiring of the tick to the engine's clear input.

## Interface
- `P_N_REQ`, 4: number of requesters (2..8).
- `P_COORD_W`, 16: signed coordinate width.
- `P_SCREEN_W`, 640: screen width in pixels; used only by clipping.
- `P_SCREEN_H`, 480: screen height in pixels; used only by clipping.

- `clk`  in  1: system clock; the block uses this one clock only.
- `rst`  in  1: asynchronous, active-high reset.
- `frame_tick`  in  1: one-cycle pulse that requests a new frame.
- `req_valid`  in  `P_N_REQ`: bit i high means requester i has a shape to draw this frame.
- `req_x0`, `req_y0`, `req_x1`, `req_y1`  in  `P_N_REQ*P_COORD_W` each: packed endpoints; requester i uses slice `[i*P_COORD_W +: P_COORD_W]`.
- `req_ack`  out  `P_N_REQ`: one-hot, one-cycle pulse when a requester's endpoints are latched.
- `eng_waiting`  in  1: engine idle, taken from `o_waiting`.
- `eng_clear`  out  1: one-cycle clear pulse, driven to `i_clear_buffer`.
- `eng_start`  out  1: one-cycle draw-start pulse.
- `eng_x0`, `eng_y0`, `eng_x1`, `eng_y1`  out  `P_COORD_W` each: registered endpoints, stable from the `eng_start` pulse until the next grant.
- `busy`  out  1: high when the FSM is in any state other than IDLE.
- `frame_done`  out  1: one-cycle pulse at the end of a frame.
- `overrun_cnt`  out  8: number of dropped frame ticks; saturates at 255.

## Operation
- FSM states: IDLE, CLR, CLR_WAIT, ARB, ISSUE, DRAW_WAIT, DONE.
- IDLE: `frame_tick` moves the FSM to CLR and clears the served mask.
- CLR: `eng_clear` is asserted for one cycle once `eng_waiting`=1. If `eng_waiting`=0, the FSM holds in CLR.
- CLR_WAIT and DRAW_WAIT:
  - The first cycle after entry is a guard cycle; `eng_waiting` is ignored.
  - After the guard cycle, the FSM leaves the state when `eng_waiting`=1. CLR_WAIT goes to ARB; DRAW_WAIT goes to ARB.
- ARB: the grant candidates are `req_valid & ~served`.
  - The grant goes to the first candidate at or above round-robin pointer `ptr`, searching upward and wrapping.
  - No candidate: the FSM goes to DONE.
- ISSUE (one cycle):
  - The granted requester's endpoints are latched into the `eng_*` registers.
  - `req_ack[g]` and `eng_start` are pulsed.
  - `served[g]` is set and `ptr` becomes (g+1) mod `P_N_REQ`.
  - The FSM then goes to DRAW_WAIT.
- DONE: `frame_done` is pulsed for one cycle, then the FSM returns to IDLE.
- Each requester is served at most once per frame.
- A `req_valid` bit that rises mid-frame is served in the same frame if ARB sees it before DONE.
- A `frame_tick` while `busy`=1 is dropped and increments `overrun_cnt` (saturating). The current frame continues unaffected.
- A `frame_tick` in the same cycle as DONE is also dropped and counted.
- `ptr` persists across frames and is reset only by `rst`.

## Timing
- Values during and after reset:
  - All outputs are 0.
  - `ptr`=0, `served`=0, FSM in IDLE.
- Assertion of `rst` at any time immediately returns the block to this state, including mid-draw. No `req_ack` or `eng_start` follows.
- Latency from `frame_tick` (cycle T, IDLE, `eng_waiting`=1):
  - `eng_clear` is high in cycle T+2 (one cycle in IDLE, one in CLR).
- The first `eng_start` is 3 cycles after the engine has re-asserted `eng_waiting` following the clear.
- `eng_start` and `req_ack` are high in the same cycle.
- `eng_x*`/`eng_y*` take their new values in that same cycle and hold them until the next ISSUE.
- With zero valid requesters, `frame_done` follows 3 cycles after the end of CLR_WAIT.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `LINE_SCHED_CLIP_EN` defined:
  - Latched x values are clamped to [0, `P_SCREEN_W`-1], comparing as signed.
  - Latched y values are clamped to [0, `P_SCREEN_H`-1], comparing as signed.
- `LINE_SCHED_CLIP_EN` undefined: endpoints pass through unchanged, and `P_SCREEN_W`/`P_SCREEN_H` are unused.

## Test plan
- Reset, then `frame_tick`, with `req_valid`=4'b0000 and the engine model always waiting:
  - `eng_clear` pulses once and `frame_done` pulses once.
  - `eng_start` never pulses and `overrun_cnt`=0.
- `req_valid`=4'b1111 with requester i driving x0=250+i, y0=200, x1=400, y1=200, and the engine model busy for 5 cycles per operation:
  - `req_ack` order is 0,1,2,3 and `eng_x0` takes 250, 251, 252, 253.
  - Exactly 4 `eng_start` pulses occur.
- Second frame with `req_valid`=4'b0101 after a frame that ended with `ptr`=2: grant order is 2, then 0.
- Three extra `frame_tick` pulses during a busy frame:
  - `overrun_cnt`=3.
  - That frame still completes with a single `frame_done`.
- `rst` asserted in DRAW_WAIT:
  - All outputs go to 0 immediately.
  - The next `frame_tick` after release grants requester 0 first.
- With `LINE_SCHED_CLIP_EN` defined, drive y0=200+incY with incY=400 and x1=-5:
  - `eng_y0` latches 479 and `eng_x1` latches 0.
  - Without the macro, the same values pass unchanged (600 and -5).
